// File: rtl/fifo_rd_stream_if.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream_if
// Bundles the FIFO read port and the valid/ready stream of fifo_rd_stream.
//   flush_i      : synchronous purge request into the adapter
//   fifo_re_o    : read enable towards the SRAM FIFO
//   fifo_rdata_i : SRAM read data, one cycle after fifo_re_o
//   fifo_empty_i : FIFO empty flag
//   valid_o      : stream data valid
//   ready_i      : stream consumer ready
//   data_o       : stream data (head of local buffer)
//   level_o      : locally held entries (0..2)
// Modport slave is the adapter's view; master is the surrounding environment.
// ---------------------------------------------------------------------------
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  flush_i;
    logic                  fifo_re_o;
    logic [DATA_WIDTH-1:0] fifo_rdata_i;
    logic                  fifo_empty_i;
    logic                  valid_o;
    logic                  ready_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic [1:0]            level_o;

    modport slave (
        input  flush_i,
        input  fifo_rdata_i,
        input  fifo_empty_i,
        input  ready_i,
        output fifo_re_o,
        output valid_o,
        output data_o,
        output level_o
    );

    modport master (
        output flush_i,
        output fifo_rdata_i,
        output fifo_empty_i,
        output ready_i,
        input  fifo_re_o,
        input  valid_o,
        input  data_o,
        input  level_o
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream
// Read-side adapter behind a synchronous SRAM FIFO. Converts the raw
// read-enable / 1-cycle read latency / empty interface into a valid/ready
// stream using a 2-entry local buffer.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : fifo_rd_stream_if.slave (FIFO read port, stream, flush, level)
// A read is only launched when the buffer is guaranteed to have room for the
// returning data, counting the read already in flight and any slot freed by
// a transfer in the same cycle. The read enable therefore depends
// combinationally on ready_i; that path is what allows one transfer per
// cycle with only two slots.
// ---------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    fifo_rd_stream_if.slave  bus
);

    logic [DATA_WIDTH-1:0] slot_r [2];
    logic                  wr_ptr_r;
    logic                  rd_ptr_r;
    logic [1:0]            cnt_r;
    logic                  pend_r;     // a FIFO read was issued last cycle
    logic                  discard_r;  // the in-flight read must be dropped

    logic                  valid_s;
    logic                  xfer_s;
    logic                  capture_s;
    logic                  re_s;
    logic [2:0]            occ_s;
    logic [2:0]            limit_s;

    // Handshake decode and read-issue decision.
    always_comb begin
        valid_s   = (cnt_r != 2'd0);
        xfer_s    = valid_s && bus.ready_i;
        capture_s = pend_r && !discard_r;
        // Room exists when held + in-flight entries stay below 2, plus one
        // more if a slot is being freed by a transfer this cycle.
        occ_s     = {1'b0, cnt_r} + {2'b00, pend_r};
        limit_s   = 3'd2 + {2'b00, xfer_s};
        // rst_ni gates the enable so nothing is popped while held in reset.
        re_s      = rst_ni && !bus.fifo_empty_i && !bus.flush_i && (occ_s < limit_s);
    end

    // Drive the interface outputs from the buffer state.
    assign bus.fifo_re_o = re_s;
    assign bus.valid_o   = valid_s;
    assign bus.data_o    = slot_r[rd_ptr_r];
    assign bus.level_o   = cnt_r;

    // Buffer storage, pointers, occupancy and read-pipeline tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_r[0] <= {DATA_WIDTH{1'b0}};
            slot_r[1] <= {DATA_WIDTH{1'b0}};
            wr_ptr_r  <= 1'b0;
            rd_ptr_r  <= 1'b0;
            cnt_r     <= 2'd0;
            pend_r    <= 1'b0;
            discard_r <= 1'b0;
        end else if (bus.flush_i) begin
            // Held entries and any data arriving this cycle are dropped;
            // re is blocked during flush so nothing new is in flight.
            wr_ptr_r  <= 1'b0;
            rd_ptr_r  <= 1'b0;
            cnt_r     <= 2'd0;
            pend_r    <= 1'b0;
            discard_r <= 1'b0;
        end else begin
            if (capture_s) begin
                slot_r[wr_ptr_r] <= bus.fifo_rdata_i;
                wr_ptr_r         <= ~wr_ptr_r;
            end else begin
                wr_ptr_r         <= wr_ptr_r;
            end
            if (xfer_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            cnt_r     <= cnt_r + {1'b0, capture_s} - {1'b0, xfer_s};
            pend_r    <= re_s;
            discard_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_stream
// Directed bench for fifo_rd_stream: a per-cycle vector table for the basic
// streaming and backpressure cases, then hand-written sequences for ready
// toggling, FIFO-empty hold, flush and mid-stream reset. A small behavioural
// SRAM FIFO supplies data with one cycle of read latency.
// ---------------------------------------------------------------------------
module tb_fifo_rd_stream;

    logic clk;
    logic rst_ni;

    fifo_rd_stream_if #(.DATA_WIDTH(32)) bus ();

    fifo_rd_stream #(.DATA_WIDTH(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM FIFO: pop on re, data visible the following cycle.
    logic [31:0] mem [0:255];
    int          head = 0;
    int          tail = 0;
    logic [31:0] rdata_q = 32'd0;

    assign bus.fifo_empty_i = (head == tail);
    assign bus.fifo_rdata_i = rdata_q;

    always @(posedge clk) begin
        if (bus.fifo_re_o) begin
            rdata_q <= mem[head];
            head    <= head + 1;
        end
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rx [0:255];
    int          rx_n = 0;

    typedef struct {
        int          push_n;
        logic [31:0] push_base;
        logic        ready;
        logic        flush;
        logic        exp_re;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [1:0]  exp_level;
    } vec_t;

    vec_t vecs [0:20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            mem[tail] = base + 32'(i);
            tail++;
        end
    endtask

    // Wait to the falling edge, check the occupancy invariant, log transfers.
    task automatic sample();
        logic ok;
        @(negedge clk);
        if (rst_ni) begin
            ok = ((32'(bus.level_o) + 32'(dut.pend_r)) <= 32'd2);
            chk("occupancy_le_2", 32'(ok), 32'd1);
            chk("discard_zero", 32'(dut.discard_r), 32'd0);
            if (bus.valid_o && bus.ready_i) begin
                rx[rx_n] = bus.data_o;
                rx_n++;
            end
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic re, input logic valid,
                           input logic [31:0] data, input logic [1:0] level);
        chk({tag, "_re"}, 32'(bus.fifo_re_o), 32'(re));
        chk({tag, "_valid"}, 32'(bus.valid_o), 32'(valid));
        chk({tag, "_level"}, 32'(bus.level_o), 32'(level));
        if (valid) chk({tag, "_data"}, bus.data_o, data);
    endtask

    initial begin
        int base;
        int cyc;

        // Streaming A0..A3 with ready held high.
        vecs[0]  = '{4, 32'hA0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0};
        vecs[1]  = '{0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0};
        vecs[2]  = '{0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hA0, 2'd1};
        vecs[3]  = '{0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hA1, 2'd1};
        vecs[4]  = '{0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'hA2, 2'd1};
        vecs[5]  = '{0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'hA3, 2'd1};
        vecs[6]  = '{0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  2'd0};
        // Backpressure with 8 entries B0..B7, then release.
        vecs[7]  = '{8, 32'hB0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0};
        vecs[8]  = '{0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0};
        vecs[9]  = '{0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'hB0, 2'd1};
        vecs[10] = '{0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'hB0, 2'd2};
        vecs[11] = '{0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'hB0, 2'd2};
        vecs[12] = '{0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hB0, 2'd2};
        vecs[13] = '{0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hB1, 2'd1};
        vecs[14] = '{0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hB2, 2'd1};
        vecs[15] = '{0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hB3, 2'd1};
        vecs[16] = '{0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hB4, 2'd1};
        vecs[17] = '{0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hB5, 2'd1};
        vecs[18] = '{0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'hB6, 2'd1};
        vecs[19] = '{0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'hB7, 2'd1};
        vecs[20] = '{0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  2'd0};

        // Reset state.
        rst_ni      = 1'b0;
        bus.ready_i = 1'b0;
        bus.flush_i = 1'b0;
        @(negedge clk);
        chk("reset_re", 32'(bus.fifo_re_o), 32'd0);
        chk("reset_valid", 32'(bus.valid_o), 32'd0);
        chk("reset_data", bus.data_o, 32'd0);
        chk("reset_level", 32'(bus.level_o), 32'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // Vector table.
        for (int i = 0; i < 21; i++) begin
            push(vecs[i].push_base, vecs[i].push_n);
            bus.ready_i = vecs[i].ready;
            bus.flush_i = vecs[i].flush;
            sample();
            chk_out($sformatf("vec%0d", i), vecs[i].exp_re, vecs[i].exp_valid,
                    vecs[i].exp_data, vecs[i].exp_level);
            next_edge();
        end

        // Ready toggling over 10 entries 0x10..0x19.
        base = rx_n;
        cyc  = 0;
        push(32'h10, 10);
        while ((rx_n - base) < 10 && cyc < 80) begin
            bus.ready_i = ((cyc % 2) == 0);
            sample();
            next_edge();
            cyc++;
        end
        chk("toggle_count", 32'(rx_n - base), 32'd10);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("toggle_data%0d", k), rx[base + k], 32'h10 + 32'(k));
        end
        bus.ready_i = 1'b0;
        sample();
        chk_out("toggle_end", 1'b0, 1'b0, 32'h0, 2'd0);
        next_edge();

        // FIFO empty with one entry held.
        push(32'h55, 1);
        sample();
        chk("hold_issue_re", 32'(bus.fifo_re_o), 32'd1);
        next_edge();
        sample();
        next_edge();
        sample();
        chk_out("hold_a", 1'b0, 1'b1, 32'h55, 2'd1);
        next_edge();
        bus.ready_i = 1'b1;
        sample();
        chk_out("hold_b", 1'b0, 1'b1, 32'h55, 2'd1);
        next_edge();
        sample();
        chk_out("hold_c", 1'b0, 1'b0, 32'h0, 2'd0);
        bus.ready_i = 1'b0;
        next_edge();

        // Flush one cycle after a read issue, with the buffer full.
        push(32'hC0, 4);
        for (int k = 0; k < 3; k++) begin
            sample();
            next_edge();
        end
        sample();
        chk_out("flush_full", 1'b0, 1'b1, 32'hC0, 2'd2);
        bus.ready_i = 1'b1;
        #1;
        chk("flush_issue_re", 32'(bus.fifo_re_o), 32'd1);
        next_edge();
        bus.ready_i = 1'b0;
        bus.flush_i = 1'b1;
        sample();
        chk("flush_pend", 32'(dut.pend_r), 32'd1);
        chk_out("flush_cyc", 1'b0, 1'b1, 32'hC1, 2'd1);
        next_edge();
        bus.flush_i = 1'b0;
        sample();
        chk_out("flush_after", 1'b1, 1'b0, 32'h0, 2'd0);
        next_edge();
        sample();
        chk_out("flush_wait", 1'b0, 1'b0, 32'h0, 2'd0);
        next_edge();
        bus.ready_i = 1'b1;
        sample();
        chk_out("flush_next", 1'b0, 1'b1, 32'hC3, 2'd1);
        next_edge();
        sample();
        chk_out("flush_drained", 1'b0, 1'b0, 32'h0, 2'd0);
        bus.ready_i = 1'b0;
        next_edge();

        // Reset mid-stream with the buffer full.
        push(32'hD0, 6);
        for (int k = 0; k < 3; k++) begin
            sample();
            next_edge();
        end
        sample();
        chk_out("rst_full", 1'b0, 1'b1, 32'hD0, 2'd2);
        rst_ni = 1'b0;
        #1;
        chk("rst_re", 32'(bus.fifo_re_o), 32'd0);
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_data", bus.data_o, 32'd0);
        chk("rst_level", 32'(bus.level_o), 32'd0);
        next_edge();
        rst_ni      = 1'b1;
        bus.ready_i = 1'b1;
        sample();
        chk_out("rst_fill0", 1'b1, 1'b0, 32'h0, 2'd0);
        next_edge();
        sample();
        chk_out("rst_fill1", 1'b1, 1'b0, 32'h0, 2'd0);
        next_edge();
        sample();
        chk_out("rst_fill2", 1'b1, 1'b1, 32'hD2, 2'd1);
        next_edge();
        sample();
        chk_out("rst_fill3", 1'b1, 1'b1, 32'hD3, 2'd1);
        next_edge();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
